// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int HDR_LEN = 2;
  localparam int CKSUM_W = 8;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport slave  (input rx_data, rx_valid, output rx_ready, im_we, im_addr, im_wdata);
  modport master (output rx_data, rx_valid, input rx_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: bytes enter at the LSB end, 4th byte completes a word.
module byte_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_done,
  output logic [31:0] o_word
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // Completed word is presented combinationally so the top can register it on the same edge.
  assign o_word_done = i_en && (r_cnt == 2'd3);
  assign o_word      = {r_shift, i_byte};
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes big-endian words to instruction memory,
// verifies the XOR checksum and releases the CPU only on a clean load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  imem_loader_if.slave  bus,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_error
);
  localparam int          LEN_W   = HDR_LEN * 8;
  localparam int unsigned MAX_N_I = 1 << ADDR_WIDTH;
  localparam logic [LEN_W:0] MAX_N = MAX_N_I[LEN_W:0];

  state_t                r_state, w_next;
  logic [LEN_W-1:0]      r_len;
  logic [ADDR_WIDTH:0]   r_wcount;
  logic [ADDR_WIDTH:0]   w_wcount_nxt;
  logic [LEN_W:0]        w_wc_ext;
  logic [CKSUM_W-1:0]    r_xor;
  logic                  r_we;
  logic [31:0]           r_addr, r_wdata;
  logic                  w_xfer, w_start_ok, w_word_done;
  logic [LEN_W-1:0]      w_len;
  logic [31:0]           w_word;

  assign bus.rx_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                        (r_state == S_WORD)   || (r_state == S_CHECK);
  assign w_xfer       = bus.rx_valid && bus.rx_ready;
  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERROR));
  assign w_len        = {r_len[LEN_W-1:8], bus.rx_data};
  assign w_wcount_nxt = r_wcount + 1'b1;
  assign w_wc_ext     = {{(LEN_W-ADDR_WIDTH){1'b0}}, w_wcount_nxt};

  byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_start_ok),
    .i_en        (w_xfer && (r_state == S_WORD)),
    .i_byte      (bus.rx_data),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (i_start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) begin
        if (w_len == '0)                 w_next = S_CHECK;
        else if ({1'b0, w_len} > MAX_N)  w_next = S_ERROR;
        else                             w_next = S_WORD;
      end
      S_WORD:  if (w_word_done && (w_wc_ext == {1'b0, r_len})) w_next = S_CHECK;
      S_CHECK: if (w_xfer) w_next = (bus.rx_data == r_xor) ? S_DONE : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len    <= '0;
      r_wcount <= '0;
      r_xor    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= w_word_done;
      if (w_word_done) begin
        r_addr   <= {{(29-ADDR_WIDTH){1'b0}}, r_wcount, 2'b00};
        r_wdata  <= w_word;
        r_wcount <= w_wcount_nxt;
      end
      if (w_start_ok) begin
        r_len    <= '0;
        r_wcount <= '0;
        r_xor    <= '0;
      end else if (w_xfer && (r_state != S_CHECK)) begin
        r_xor <= r_xor ^ bus.rx_data;
      end
      if (w_xfer && (r_state == S_LEN_HI)) r_len[LEN_W-1:8] <= bus.rx_data;
      if (w_xfer && (r_state == S_LEN_LO)) r_len[7:0]       <= bus.rx_data;
    end
  end

  assign bus.im_we    = r_we;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = r_wdata;
  assign o_done       = (r_state == S_DONE);
  assign o_error      = (r_state == S_ERROR);
  assign o_cpu_hold   = (r_state != S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are scored against a byte-list model
// that derives writes and pass/fail directly from the frame contents.
module tb_imem_loader;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .bus        (bus),
    .o_cpu_hold (cpu_hold),
    .o_done     (done),
    .o_error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  frame[$];
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  bit exp_done, exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.im_we) begin
      got_a.push_back(bus.im_addr);
      got_d.push_back(bus.im_wdata);
    end
  end

  // Build a frame of n words; oversize frames carry only the header.
  task automatic gen_frame(input int n, input bit bad);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n & 255));
    if (n > CAP) return;
    for (int i = 0; i < n * 4; i++) frame.push_back(8'($urandom));
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(bad ? (x ^ (8'h01 << $urandom_range(0, 7))) : x);
  endtask

  task automatic model();
    int n;
    logic [7:0] x;
    exp_a.delete();
    exp_d.delete();
    n = {frame[0], frame[1]};
    if (n > CAP) begin
      exp_done = 0;
      exp_err  = 1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_a.push_back(32'(w * 4));
      exp_d.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
    end
    x = 8'h00;
    for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
    exp_done = (frame[frame.size()-1] == x);
    exp_err  = !exp_done;
  endtask

  task automatic send_bytes(input bit stall, input int busy_at, output bit ok);
    int i = 0;
    int budget = 0;
    logic rdy;
    ok = 1;
    while (i < frame.size()) begin
      bus.rx_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.rx_data  = frame[i];
      start        = (i == busy_at);
      rdy          = bus.rx_ready;
      @(posedge clk); #1;
      if (bus.rx_valid && rdy) i++;
      budget++;
      if (budget > 2000) begin
        ok = 0;
        break;
      end
    end
    bus.rx_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".rdy_after_start"}, bus.rx_ready, 1);
    chk({tag, ".done_cleared"}, done, 0);
    chk({tag, ".hold_set"}, cpu_hold, 1);
  endtask

  task automatic load(input string tag, input bit stall, input int busy_at);
    bit ok;
    model();
    got_a.delete();
    got_d.delete();
    pulse_start(tag);
    send_bytes(stall, busy_at, ok);
    chk({tag, ".no_timeout"}, ok, 1);
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".cpu_hold"}, cpu_hold, !exp_done);
    chk({tag, ".rdy_end"}, bus.rx_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".nwrites"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk({tag, ".addr"}, got_a[i], exp_a[i]);
      chk({tag, ".data"}, got_d[i], exp_d[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rdy"}, bus.rx_ready, 0);
    chk({tag, ".we"}, bus.im_we, 0);
    chk({tag, ".addr"}, bus.im_addr, 0);
    chk({tag, ".wdata"}, bus.im_wdata, 0);
    chk({tag, ".hold"}, cpu_hold, 1);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".error"}, error, 0);
  endtask

  initial begin
    bit ok;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h10, 8'h00, 8'h0A, 8'h15};
    load("good", 0, -1);
    if (got_d.size() == 2) begin
      chk("good.w0", got_d[0], 32'h20080005);
      chk("good.w1", got_d[1], 32'h2010000A);
    end else chk("good.count2", got_d.size(), 2);

    frame[frame.size()-1] = 8'h14;
    load("badck", 0, -1);

    frame = '{8'h00, 8'h11};
    load("oversize", 0, -1);

    frame = '{8'h00, 8'h00, 8'h00};
    load("empty", 0, -1);

    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h10, 8'h00, 8'h0A, 8'h15};
    load("stall", 1, -1);
    load("busy_start", 0, 5);

    gen_frame(CAP, 0);
    load("full_cap", 1, -1);
    gen_frame(CAP, 1);
    load("full_cap_bad", 0, -1);

    for (int t = 0; t < 10; t++) begin
      gen_frame($urandom_range(0, CAP + 2), $urandom_range(0, 3) == 0);
      load("rand", $urandom_range(0, 1), $urandom_range(0, 1) ? 6 : -1);
    end

    // Reset lands after two bytes of word 1; only word 0 may be written.
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h10};
    got_a.delete();
    got_d.delete();
    pulse_start("midrst");
    send_bytes(0, -1, ok);
    chk("midrst.no_timeout", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.nwrites", got_a.size(), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h10, 8'h00, 8'h0A, 8'h15};
    load("after_rst", 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
